// File: rtl/controle_busca.sv
// Fetch-stage controller: owns the PC, the IF/ID pipeline register and the
// arbitration of the instruction-memory address port with the program loader.
module controle_busca #(
  parameter logic [31:0] RESET_VECTOR = 32'h0000_0000,
  parameter logic [31:0] NOP_WORD     = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        stall,
  input  logic        branch_taken,
  input  logic [31:0] branch_target,
  input  logic        halt_req,
  input  logic        load_req,
  input  logic [31:0] load_addr,
  input  logic        load_done,
  input  logic [31:0] imem_instr,
  output logic [31:0] imem_addr,
  output logic [31:0] pc,
  output logic        load_gnt,
  output logic        halted,
  output logic [31:0] if_id_instr,
  output logic [31:0] if_id_pc4,
  output logic        if_id_valid
);

  typedef enum logic [1:0] {RUN = 2'd0, HALT = 2'd1, LOAD = 2'd2} state_t;

  state_t      state_r, next_state_s;
  logic [31:0] pc_r, pc_next_s, pc_plus4_s;
  logic [31:0] instr_r, instr_next_s;
  logic [31:0] pc4_r, pc4_next_s;
  logic        valid_r, valid_next_s;
  logic        gnt_r, gnt_next_s;
  logic        halted_r, halted_next_s;
  logic [31:0] branch_pc_s;
  logic [31:0] reset_pc_s;
  logic        unused_target_bits_s;

  assign pc_plus4_s           = pc_r + 32'd4;
  assign branch_pc_s          = {branch_target[31:2], 2'b00};
  assign reset_pc_s           = {RESET_VECTOR[31:2], 2'b00};
  assign unused_target_bits_s = ^branch_target[1:0];

  // State register
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r <= RUN;
    end else begin
      state_r <= next_state_s;
    end
  end

  // Next-state selection; load beats everything, then branch, then halt
  always_comb begin
    next_state_s = state_r;
    case (state_r)
      RUN: begin
        if (load_req) begin
          next_state_s = LOAD;
        end else if (branch_taken) begin
          next_state_s = RUN;
        end else if (halt_req) begin
          next_state_s = HALT;
        end else begin
          next_state_s = RUN;
        end
      end
      HALT: begin
        if (load_req) begin
          next_state_s = LOAD;
        end else if (!halt_req) begin
          next_state_s = RUN;
        end else begin
          next_state_s = HALT;
        end
      end
      LOAD: begin
        if (load_done) begin
          next_state_s = RUN;
        end else begin
          next_state_s = LOAD;
        end
      end
      default: next_state_s = RUN;
    endcase
  end

  // Next values of PC, IF/ID and status flags; defaults hold everything
  always_comb begin
    pc_next_s     = pc_r;
    instr_next_s  = instr_r;
    pc4_next_s    = pc4_r;
    valid_next_s  = valid_r;
    gnt_next_s    = gnt_r;
    halted_next_s = halted_r;
    case (state_r)
      RUN: begin
        if (load_req) begin
          instr_next_s  = NOP_WORD;
          valid_next_s  = 1'b0;
          gnt_next_s    = 1'b1;
          halted_next_s = 1'b0;
        end else if (branch_taken) begin
          pc_next_s    = branch_pc_s;
          instr_next_s = NOP_WORD;
          valid_next_s = 1'b0;
        end else if (halt_req) begin
          instr_next_s  = NOP_WORD;
          valid_next_s  = 1'b0;
          halted_next_s = 1'b1;
        end else if (stall) begin
          pc_next_s = pc_r;
        end else begin
          pc_next_s    = pc_plus4_s;
          instr_next_s = imem_instr;
          pc4_next_s   = pc_plus4_s;
          valid_next_s = 1'b1;
        end
      end
      HALT: begin
        if (load_req) begin
          instr_next_s  = NOP_WORD;
          valid_next_s  = 1'b0;
          gnt_next_s    = 1'b1;
          halted_next_s = 1'b0;
        end else if (!halt_req) begin
          halted_next_s = 1'b0;
        end else begin
          halted_next_s = 1'b1;
        end
      end
      LOAD: begin
        if (load_done) begin
          pc_next_s  = reset_pc_s;
          gnt_next_s = 1'b0;
        end else begin
          gnt_next_s = 1'b1;
        end
      end
      default: begin
        pc_next_s = pc_r;
      end
    endcase
  end

  // Datapath and status registers
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pc_r     <= reset_pc_s;
      instr_r  <= NOP_WORD;
      pc4_r    <= 32'h0000_0000;
      valid_r  <= 1'b0;
      gnt_r    <= 1'b0;
      halted_r <= 1'b0;
    end else begin
      pc_r     <= pc_next_s;
      instr_r  <= instr_next_s;
      pc4_r    <= pc4_next_s;
      valid_r  <= valid_next_s;
      gnt_r    <= gnt_next_s;
      halted_r <= halted_next_s;
    end
  end

  // The loader drives the memory address only while it holds the port
  always_comb begin
    if (state_r == LOAD) begin
      imem_addr = load_addr;
    end else begin
      imem_addr = pc_r;
    end
  end

  assign pc          = pc_r;
  assign load_gnt    = gnt_r;
  assign halted      = halted_r;
  assign if_id_instr = instr_r;
  assign if_id_pc4   = pc4_r;
  assign if_id_valid = valid_r;

endmodule

// File: tb/tb_controle_busca.sv
// Table-driven bench for controle_busca: each record holds one cycle of inputs
// and the register state expected after the following rising edge.
module tb_controle_busca;

  logic        clk = 1'b0;
  logic        rst_n, stall, branch_taken, halt_req, load_req, load_done;
  logic [31:0] branch_target, load_addr, imem_instr, imem_addr, pc;
  logic [31:0] if_id_instr, if_id_pc4;
  logic        load_gnt, halted, if_id_valid;
  logic [31:0] mem [0:63];

  typedef struct {
    logic        rst_n, stall, br;
    logic [31:0] tgt;
    logic        halt, lreq;
    logic [31:0] laddr;
    logic        ldone, chk_addr;
    logic [31:0] exp_addr, pc, instr, pc4;
    logic        valid, gnt, halted;
  } vec_t;

  vec_t tbl [0:28];
  vec_t sb [$];
  int   pass_cnt = 0;
  int   total_cnt = 0;

  controle_busca dut (
    .clk(clk), .rst_n(rst_n), .stall(stall), .branch_taken(branch_taken),
    .branch_target(branch_target), .halt_req(halt_req), .load_req(load_req),
    .load_addr(load_addr), .load_done(load_done), .imem_instr(imem_instr),
    .imem_addr(imem_addr), .pc(pc), .load_gnt(load_gnt), .halted(halted),
    .if_id_instr(if_id_instr), .if_id_pc4(if_id_pc4), .if_id_valid(if_id_valid)
  );

  always #5 clk = ~clk;

  assign imem_instr = mem[imem_addr[7:2]];

  function automatic vec_t mkv(
    input logic r, st, br, input logic [31:0] tgt, input logic hl, lr,
    input logic [31:0] la, input logic ld, ca, input logic [31:0] ea,
    input logic [31:0] p, ins, p4, input logic v, g, h);
    vec_t x;
    x.rst_n = r; x.stall = st; x.br = br; x.tgt = tgt; x.halt = hl; x.lreq = lr;
    x.laddr = la; x.ldone = ld; x.chk_addr = ca; x.exp_addr = ea;
    x.pc = p; x.instr = ins; x.pc4 = p4; x.valid = v; x.gnt = g; x.halted = h;
    return x;
  endfunction

  task automatic chk(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act === exp) begin
      pass_cnt++;
    end else begin
      $display("FAIL step %0d %s: got %h, expected %h", idx, name, act, exp);
    end
  endtask

  task automatic apply(input vec_t v, input int idx);
    vec_t e;
    @(negedge clk);
    rst_n = v.rst_n; stall = v.stall; branch_taken = v.br; branch_target = v.tgt;
    halt_req = v.halt; load_req = v.lreq; load_addr = v.laddr; load_done = v.ldone;
    #1;
    if (v.chk_addr) chk("imem_addr", idx, imem_addr, v.exp_addr);
    sb.push_back(v);
    @(posedge clk);
    #1;
    e = sb.pop_front();
    chk("pc", idx, pc, e.pc);
    chk("if_id_instr", idx, if_id_instr, e.instr);
    chk("if_id_pc4", idx, if_id_pc4, e.pc4);
    chk("if_id_valid", idx, {31'd0, if_id_valid}, {31'd0, e.valid});
    chk("load_gnt", idx, {31'd0, load_gnt}, {31'd0, e.gnt});
    chk("halted", idx, {31'd0, halted}, {31'd0, e.halted});
  endtask

  initial begin
    for (int i = 0; i < 64; i++) mem[i] = 32'hA000_0000 | i;
    mem[0]  = 32'h2421_0005;
    mem[1]  = 32'h2442_000A;
    mem[2]  = 32'h0022_1821;
    mem[3]  = 32'h0041_2023;
    mem[63] = 32'hDEAD_BEEF;
    rst_n = 1'b0; stall = 1'b0; branch_taken = 1'b0; branch_target = 32'h0;
    halt_req = 1'b0; load_req = 1'b0; load_addr = 32'h0; load_done = 1'b0;

    // reset and straight-line fetch
    tbl[0]  = mkv(1'b0,1'b0,1'b0,32'h0,1'b0,1'b0,32'h0,1'b0, 1'b0,32'h0,  32'h0,32'h0,32'h0,1'b0,1'b0,1'b0);
    tbl[1]  = mkv(1'b1,1'b0,1'b0,32'h0,1'b0,1'b0,32'h0,1'b0, 1'b1,32'h0,  32'h4,32'h24210005,32'h4,1'b1,1'b0,1'b0);
    tbl[2]  = mkv(1'b1,1'b0,1'b0,32'h0,1'b0,1'b0,32'h0,1'b0, 1'b1,32'h4,  32'h8,32'h2442000A,32'h8,1'b1,1'b0,1'b0);
    tbl[3]  = mkv(1'b1,1'b0,1'b0,32'h0,1'b0,1'b0,32'h0,1'b0, 1'b1,32'h8,  32'hC,32'h00221821,32'hC,1'b1,1'b0,1'b0);
    tbl[4]  = mkv(1'b1,1'b0,1'b0,32'h0,1'b0,1'b0,32'h0,1'b0, 1'b1,32'hC,  32'h10,32'h00412023,32'h10,1'b1,1'b0,1'b0);
    // branch back, then stall two cycles at pc=8
    tbl[5]  = mkv(1'b1,1'b0,1'b1,32'h5,1'b0,1'b0,32'h0,1'b0, 1'b1,32'h10, 32'h4,32'h0,32'h10,1'b0,1'b0,1'b0);
    tbl[6]  = mkv(1'b1,1'b0,1'b0,32'h0,1'b0,1'b0,32'h0,1'b0, 1'b1,32'h4,  32'h8,32'h2442000A,32'h8,1'b1,1'b0,1'b0);
    tbl[7]  = mkv(1'b1,1'b1,1'b0,32'h0,1'b0,1'b0,32'h0,1'b0, 1'b1,32'h8,  32'h8,32'h2442000A,32'h8,1'b1,1'b0,1'b0);
    tbl[8]  = mkv(1'b1,1'b1,1'b0,32'h0,1'b0,1'b0,32'h0,1'b0, 1'b1,32'h8,  32'h8,32'h2442000A,32'h8,1'b1,1'b0,1'b0);
    tbl[9]  = mkv(1'b1,1'b0,1'b0,32'h0,1'b0,1'b0,32'h0,1'b0, 1'b1,32'h8,  32'hC,32'h00221821,32'hC,1'b1,1'b0,1'b0);
    // branch overrides stall, target low bits dropped
    tbl[10] = mkv(1'b1,1'b1,1'b1,32'h6,1'b0,1'b0,32'h0,1'b0, 1'b1,32'hC,  32'h4,32'h0,32'hC,1'b0,1'b0,1'b0);
    tbl[11] = mkv(1'b1,1'b0,1'b0,32'h0,1'b0,1'b0,32'h0,1'b0, 1'b1,32'h4,  32'h8,32'h2442000A,32'h8,1'b1,1'b0,1'b0);
    // halt for three cycles; stall/branch ignored while halted
    tbl[12] = mkv(1'b1,1'b0,1'b0,32'h0,1'b1,1'b0,32'h0,1'b0, 1'b1,32'h8,  32'h8,32'h0,32'h8,1'b0,1'b0,1'b1);
    tbl[13] = mkv(1'b1,1'b1,1'b1,32'h40,1'b1,1'b0,32'h0,1'b0,1'b1,32'h8,  32'h8,32'h0,32'h8,1'b0,1'b0,1'b1);
    tbl[14] = mkv(1'b1,1'b0,1'b0,32'h0,1'b1,1'b0,32'h0,1'b0, 1'b1,32'h8,  32'h8,32'h0,32'h8,1'b0,1'b0,1'b1);
    tbl[15] = mkv(1'b1,1'b0,1'b0,32'h0,1'b0,1'b0,32'h0,1'b0, 1'b1,32'h8,  32'h8,32'h0,32'h8,1'b0,1'b0,1'b0);
    tbl[16] = mkv(1'b1,1'b0,1'b0,32'h0,1'b0,1'b0,32'h0,1'b0, 1'b1,32'h8,  32'hC,32'h00221821,32'hC,1'b1,1'b0,1'b0);
    tbl[17] = mkv(1'b1,1'b0,1'b0,32'h0,1'b0,1'b0,32'h0,1'b0, 1'b1,32'hC,  32'h10,32'h00412023,32'h10,1'b1,1'b0,1'b0);
    // load beats branch/halt; loader owns imem_addr; load_req drop keeps LOAD
    tbl[18] = mkv(1'b1,1'b0,1'b1,32'h40,1'b1,1'b1,32'h20,1'b0,1'b1,32'h10, 32'h10,32'h0,32'h10,1'b0,1'b1,1'b0);
    tbl[19] = mkv(1'b1,1'b1,1'b1,32'h40,1'b1,1'b1,32'h20,1'b0,1'b1,32'h20, 32'h10,32'h0,32'h10,1'b0,1'b1,1'b0);
    tbl[20] = mkv(1'b1,1'b0,1'b0,32'h0,1'b0,1'b1,32'h24,1'b0, 1'b1,32'h24, 32'h10,32'h0,32'h10,1'b0,1'b1,1'b0);
    tbl[21] = mkv(1'b1,1'b0,1'b0,32'h0,1'b0,1'b0,32'h28,1'b0, 1'b1,32'h28, 32'h10,32'h0,32'h10,1'b0,1'b1,1'b0);
    tbl[22] = mkv(1'b1,1'b0,1'b0,32'h0,1'b0,1'b0,32'h2C,1'b1, 1'b1,32'h2C, 32'h0,32'h0,32'h10,1'b0,1'b0,1'b0);
    tbl[23] = mkv(1'b1,1'b0,1'b0,32'h0,1'b0,1'b0,32'h0,1'b0, 1'b1,32'h0,  32'h4,32'h24210005,32'h4,1'b1,1'b0,1'b0);
    // stray load_done in RUN is ignored
    tbl[24] = mkv(1'b1,1'b0,1'b0,32'h0,1'b0,1'b0,32'h0,1'b1, 1'b1,32'h4,  32'h8,32'h2442000A,32'h8,1'b1,1'b0,1'b0);
    // load from HALT clears halted; reset during LOAD aborts it
    tbl[25] = mkv(1'b1,1'b0,1'b0,32'h0,1'b1,1'b0,32'h0,1'b0, 1'b1,32'h8,  32'h8,32'h0,32'h8,1'b0,1'b0,1'b1);
    tbl[26] = mkv(1'b1,1'b0,1'b0,32'h0,1'b1,1'b1,32'h30,1'b0,1'b1,32'h8,  32'h8,32'h0,32'h8,1'b0,1'b1,1'b0);
    tbl[27] = mkv(1'b1,1'b0,1'b0,32'h0,1'b0,1'b1,32'h30,1'b0,1'b1,32'h30, 32'h8,32'h0,32'h8,1'b0,1'b1,1'b0);
    tbl[28] = mkv(1'b0,1'b0,1'b0,32'h0,1'b0,1'b1,32'h30,1'b0,1'b1,32'h30, 32'h0,32'h0,32'h0,1'b0,1'b0,1'b0);

    for (int i = 0; i <= 28; i++) apply(tbl[i], i);

    // PC wrap from the top of the address space
    apply(mkv(1'b1,1'b0,1'b0,32'h0,1'b0,1'b0,32'h0,1'b0, 1'b1,32'h0, 32'h4,32'h24210005,32'h4,1'b1,1'b0,1'b0), 100);
    apply(mkv(1'b1,1'b0,1'b1,32'hFFFFFFFF,1'b0,1'b0,32'h0,1'b0, 1'b1,32'h4, 32'hFFFFFFFC,32'h0,32'h4,1'b0,1'b0,1'b0), 101);
    apply(mkv(1'b1,1'b0,1'b0,32'h0,1'b0,1'b0,32'h0,1'b0, 1'b1,32'hFFFFFFFC, 32'h0,32'hDEADBEEF,32'h0,1'b1,1'b0,1'b0), 102);
    apply(mkv(1'b1,1'b0,1'b0,32'h0,1'b0,1'b0,32'h0,1'b0, 1'b1,32'h0, 32'h4,32'h24210005,32'h4,1'b1,1'b0,1'b0), 103);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
